instr_encoder: RTL

//  Inverse of the core's immediate generator: packs opcode, register fields,

---
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields and a signed immediate into a
// 32-bit instruction word (R/I/S/B/U/J). The immediate is range and alignment
// checked, and any error replaces the word with NOP_WORD. The block is a
// two-stage valid/ready pipeline. Stage 1 holds the fields and the error code.
// Stage 2 holds the packed word. A saturating counter tallies the errored
// words that leave the block.
module instr_encoder #(
    parameter int          ERR_CNT_W = 16,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic signed [31:0]   in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [1:0]           out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_FMT   = 2'b11;

    // Error classification. An illegal format beats misalignment, and
    // misalignment beats range.
    function automatic logic [1:0] calc_err(input logic [2:0] fmt, input logic signed [31:0] imm);
        logic [1:0] e;
        e = ERR_OK;
        case (fmt)
            FMT_R: e = ERR_OK;
            FMT_I, FMT_S: begin
                if (imm < -32'sd2048 || imm > 32'sd2047) e = ERR_RANGE;
            end
            FMT_B: begin
                if (imm[0])                                   e = ERR_ALIGN;
                else if (imm < -32'sd4096 || imm > 32'sd4094) e = ERR_RANGE;
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) e = ERR_RANGE;
            end
            FMT_J: begin
                if (imm[0])                                         e = ERR_ALIGN;
                else if (imm < -32'sd1048576 || imm > 32'sd1048574) e = ERR_RANGE;
            end
            default: e = ERR_FMT;
        endcase
        return e;
    endfunction

    // Field placement for each format. Fields that a format does not use are dropped.
    function automatic logic [31:0] pack(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic signed [31:0] imm);
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    // Saturating increment. The counter holds at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                 vld_p1;
    logic                 vld_p2;
    logic [2:0]           fmt_p1;
    logic [6:0]           opcode_p1;
    logic [4:0]           rd_p1;
    logic [4:0]           rs1_p1;
    logic [4:0]           rs2_p1;
    logic [2:0]           funct3_p1;
    logic [6:0]           funct7_p1;
    logic signed [31:0]   imm_p1;
    logic [1:0]           err_p1;
    logic [31:0]          instr_p2;
    logic [1:0]           err_p2;
    logic [ERR_CNT_W-1:0] cnt;
    logic                 adv_p2;
    logic                 take_p1;
    logic                 take_p2;
    logic                 drain_err;

    assign adv_p2    = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || adv_p2;
    assign take_p1   = in_valid && in_ready;
    assign take_p2   = vld_p1 && adv_p2;
    assign drain_err = vld_p2 && out_ready && (err_p2 != ERR_OK);

    // Stage valids: stage 1 refills whenever it can advance, and stage 2 follows stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (adv_p2)   vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: capture fields and the registered error code ----
    always_ff @(posedge clk) begin
        if (take_p1) begin
            fmt_p1    <= in_fmt;
            opcode_p1 <= in_opcode;
            rd_p1     <= in_rd;
            rs1_p1    <= in_rs1;
            rs2_p1    <= in_rs2;
            funct3_p1 <= in_funct3;
            funct7_p1 <= in_funct7;
            imm_p1    <= in_imm;
            err_p1    <= calc_err(in_fmt, in_imm);
        end
    end

    // ---- stage 2: packed word, or NOP when stage 1 flagged an error ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p2 <= 32'd0;
            err_p2   <= ERR_OK;
        end else if (take_p2) begin
            instr_p2 <= (err_p1 != ERR_OK) ? NOP_WORD
                        : pack(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1, funct3_p1, funct7_p1, imm_p1);
            err_p2   <= err_p1;
        end
    end

    // Count errored words as they are handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         cnt <= '0;
        else if (drain_err) cnt <= sat_inc(cnt);
    end

    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_err   = err_p2;
    assign err_cnt   = cnt;

endmodule
